// File: rtl/d_grf_mp_pkg.sv
// Shared defaults for the D-stage general register file.
package d_grf_mp_pkg;
    localparam int DW_DEF   = 32;
    localparam int AW_DEF   = 5;
    localparam int ZERO_REG = 0;    // hardwired-zero register index
endpackage

// File: rtl/grf_bypass_sel.sv
// One read port: W->D bypass priority select over all write ports plus busy masking.
module grf_bypass_sel
    import d_grf_mp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NW = 2
) (
    input  logic [AW-1:0]    ra,
    input  logic [DW-1:0]    arr_rd,
    input  logic             arr_busy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*DW-1:0] wd,
    output logic [DW-1:0]    rd,
    output logic             rbusy
);
    localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

    logic hit;

    // Ascending scan so the highest-indexed matching port is the last assignment.
    always_comb begin
        rd  = arr_rd;
        hit = 1'b0;
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa[j*AW +: AW] == ra) begin
                rd  = wd[j*DW +: DW];
                hit = 1'b1;
            end
        end
        if (ra == ZA) rd = '0;
        // A same-cycle write resolves the hazard through the bypass.
        rbusy = arr_busy && !hit && (ra != ZA);
    end
endmodule

// File: rtl/d_grf_mp.sv
// Multi-port GRF with W->D bypass and per-register busy scoreboard; r0 reads zero.
module d_grf_mp
    import d_grf_mp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int NR = 2,
    parameter int NW = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] wa,
    input  logic [NW*DW-1:0] wd,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_a,
    input  logic             flush
);
    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] ZA    = AW'(ZERO_REG);

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    // Later ports overwrite earlier ones, giving the highest index priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa[j*AW +: AW] != ZA)
                    regs[wa[j*AW +: AW]] <= wd[j*DW +: DW];
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (we[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
            end
            // Issue after clears: a reservation beats a same-cycle write-back.
            if (iss_en) busy_nxt[iss_a] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        grf_bypass_sel #(
            .DW (DW),
            .AW (AW),
            .NW (NW)
        ) u_sel (
            .ra       (ra[i*AW +: AW]),
            .arr_rd   (regs[ra[i*AW +: AW]]),
            .arr_busy (busy[ra[i*AW +: AW]]),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .rd       (rd[i*DW +: DW]),
            .rbusy    (rbusy[i])
        );
    end
endmodule

// File: tb/tb_d_grf_mp.sv
// Scoreboard bench for d_grf_mp: reference model pushes expected reads, negedge monitor compares.
module tb_d_grf_mp;
    localparam int DW = 32, AW = 5, NR = 2, NW = 2, D = 1 << AW;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic [NW-1:0]    we;
    logic [NW*AW-1:0] wa;
    logic [NW*DW-1:0] wd;
    logic             iss_en;
    logic [AW-1:0]    iss_a;
    logic             flush;

    always #5 clk = ~clk;

    d_grf_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_a(iss_a), .flush(flush)
    );

    typedef struct {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mreg [D];
    bit            mbusy[D];
    int            checks = 0;
    int            passed = 0;

    // Expected read data: zero for r0, else newest same-cycle write, else stored value.
    function automatic exp_t model_read();
        exp_t e;
        for (int i = 0; i < NR; i++) begin
            int            a;
            bit            hit;
            logic [DW-1:0] d;
            a   = int'(ra[i*AW +: AW]);
            hit = 0;
            d   = mreg[a];
            for (int j = NW - 1; j >= 0; j--) begin
                if (!hit && we[j] && int'(wa[j*AW +: AW]) == a) begin
                    d   = wd[j*DW +: DW];
                    hit = 1;
                end
            end
            e.rd[i*DW +: DW] = (a == 0) ? '0 : d;
            e.rb[i]          = (a != 0) && mbusy[a] && !hit;
        end
        return e;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int k = 0; k < D; k++) begin mreg[k] = '0; mbusy[k] = 0; end
        end else begin
            for (int j = 0; j < NW; j++)
                if (we[j] && wa[j*AW +: AW] != 0) mreg[int'(wa[j*AW +: AW])] = wd[j*DW +: DW];
            if (flush) begin
                for (int k = 0; k < D; k++) mbusy[k] = 0;
            end else begin
                for (int j = 0; j < NW; j++) if (we[j]) mbusy[int'(wa[j*AW +: AW])] = 0;
                if (iss_en && iss_a != 0) mbusy[int'(iss_a)] = 1;
            end
        end
    endtask

    // Push this cycle's expectation, then advance one clock edge.
    task automatic tick();
        q.push_back(model_read());
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; we = '0; wa = '0; wd = '0; iss_en = 0; iss_a = '0; flush = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("sb_rd%0d ra=%0d", i, ra[i*AW +: AW]), 64'(rd[i*DW +: DW]), 64'(e.rd[i*DW +: DW]));
                chk($sformatf("sb_rbusy%0d ra=%0d", i, ra[i*AW +: AW]), 64'(rbusy[i]), 64'(e.rb[i]));
            end
        end
    end

    initial begin
        idle(); ra = '0; reset = 1;
        @(posedge clk); model_edge(); #1;
        idle();

        // Preload all registers with ones and reserve them, then reset.
        for (int a = 1; a < D; a++) begin
            we = 2'b01; wa = {AW'(0), AW'(a)}; wd = {32'h0, 32'hFFFF_FFFF};
            iss_en = 1; iss_a = AW'(a); ra = {AW'(a - 1), AW'(a)};
            tick();
        end
        idle(); reset = 1; tick();
        idle();
        for (int a = 0; a < D; a += 2) begin
            ra = {AW'(a + 1), AW'(a)}; #1;
            chk("reset_rd", 64'(rd), 64'(0));
            chk("reset_rbusy", 64'(rbusy), 64'(0));
            tick();
        end

        // Write with same-cycle bypass, then read back from the array.
        we = 2'b01; wa = {AW'(0), AW'(5)}; wd = {32'h0, 32'h1234_5678}; ra = {AW'(5), AW'(5)}; #1;
        chk("wr_bypass", 64'(rd), {2{32'h1234_5678}});
        tick(); idle(); #1;
        chk("wr_array", 64'(rd), {2{32'h1234_5678}});
        tick();

        // Zero register ignores writes and reservations.
        we = 2'b10; wa = {AW'(0), AW'(0)}; wd = {32'hDEAD_BEEF, 32'h0};
        iss_en = 1; iss_a = '0; ra = '0; #1;
        chk("r0_rd_same", 64'(rd), 64'(0));
        chk("r0_rbusy_same", 64'(rbusy), 64'(0));
        tick(); idle(); #1;
        chk("r0_rd_next", 64'(rd), 64'(0));
        chk("r0_rbusy_next", 64'(rbusy), 64'(0));
        tick();

        // Same-address writes: port 1 wins.
        we = 2'b11; wa = {AW'(7), AW'(7)}; wd = {32'hB, 32'hA}; ra = {AW'(7), AW'(7)}; #1;
        chk("prio_same", 64'(rd), {2{32'hB}});
        tick(); idle(); #1;
        chk("prio_next", 64'(rd), {2{32'hB}});
        tick();

        // Scoreboard set, clear by write-back, and set-beats-clear.
        iss_en = 1; iss_a = 5'd9; ra = {AW'(9), AW'(9)}; tick();
        idle(); #1;
        chk("sb_set", 64'(rbusy), 64'(2'b11));
        tick();
        we = 2'b01; wa = {AW'(0), AW'(9)}; wd = {32'h0, 32'h55}; #1;
        chk("sb_wb_rbusy", 64'(rbusy), 64'(0));
        chk("sb_wb_rd", 64'(rd), {2{32'h55}});
        tick();
        we = 2'b01; wa = {AW'(0), AW'(9)}; wd = {32'h0, 32'h66}; iss_en = 1; iss_a = 5'd9; tick();
        idle(); #1;
        chk("sb_set_wins", 64'(rbusy), 64'(2'b11));
        tick();

        // Flush clears everything and drops a same-cycle issue.
        iss_en = 1; iss_a = 5'd3; tick();
        iss_a = 5'd4; tick();
        idle(); ra = {AW'(4), AW'(3)}; #1;
        chk("fl_pre", 64'(rbusy), 64'(2'b11));
        flush = 1; iss_en = 1; iss_a = 5'd6; tick();
        idle(); #1;
        chk("fl_34", 64'(rbusy), 64'(0));
        ra = {AW'(6), AW'(6)}; #1;
        chk("fl_6", 64'(rbusy), 64'(0));
        tick();

        // Randomized traffic concentrated on a few addresses to provoke collisions.
        for (int n = 0; n < 500; n++) begin
            reset  = ($urandom_range(0, 99) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            we     = NW'($urandom);
            iss_en = $urandom_range(0, 1);
            iss_a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            for (int j = 0; j < NW; j++) begin
                wa[j*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                wd[j*DW +: DW] = DW'($urandom);
            end
            for (int i = 0; i < NR; i++)
                ra[i*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            tick();
        end
        idle();

        // Let the monitor drain, with a bounded wait.
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL sb_drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
